// File: rtl/fabric_common.sv
// Shared fabric definitions: runtime error codes and a pointer-width helper
// that stays at least one bit wide for single-entry storage.
package fabric_common;

  localparam logic [15:0] RT_TEMPORAL_ALIGN_TAG_MISMATCH = 16'd262;

  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fabric_lane_fifo.sv
// Single-lane FIFO with a registered occupancy count; the head is read
// straight from storage, so a pushed entry is visible one cycle later.
module fabric_lane_fifo
  import fabric_common::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = ptr_w(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fabric_temporal_operand_align.sv
// Aligns tagged operand lanes ahead of the temporal PE: a set is offered only
// when every lane head holds data with the lane-0 tag; tag skew freezes the stage.
module fabric_temporal_operand_align
  import fabric_common::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 2,
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
  localparam int CW = ptr_w(DEPTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_INPUTS-1:0]                   in_valid,
  output logic [NUM_INPUTS-1:0]                   in_ready,
  input  logic [NUM_INPUTS-1:0][PAYLOAD_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]                   out_valid,
  input  logic [NUM_INPUTS-1:0]                   out_ready,
  output logic [NUM_INPUTS-1:0][PAYLOAD_WIDTH-1:0] out_data,
  output logic                                    error_valid,
  output logic [15:0]                             error_code
);

  if (NUM_INPUTS < 1) begin : g_bad_num_inputs
    $fatal(1, "fabric_temporal_operand_align: NUM_INPUTS must be >= 1");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $fatal(1, "fabric_temporal_operand_align: TAG_WIDTH must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "fabric_temporal_operand_align: DEPTH must be >= 1");
  end

  logic [NUM_INPUTS-1:0]         lane_push;
  logic [NUM_INPUTS-1:0]         lane_full;
  logic [NUM_INPUTS-1:0]         lane_empty;
  logic [NUM_INPUTS-1:0][CW-1:0] lane_count;
  logic                          all_nonempty;
  logic                          tags_match;
  logic                          heads_ok;
  logic                          mismatch;
  logic                          fire;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    // Readiness follows the registered count only, so a full lane never
    // accepts in the same cycle it pops.
    assign in_ready[i]  = (lane_count[i] < CW'(DEPTH)) && !error_valid;
    assign lane_push[i] = in_valid[i] && in_ready[i] && !lane_full[i];

    fabric_lane_fifo #(
      .WIDTH (PAYLOAD_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (lane_push[i]),
      .pop   (fire),
      .wdata (in_data[i]),
      .head  (out_data[i]),
      .count (lane_count[i]),
      .full  (lane_full[i]),
      .empty (lane_empty[i])
    );
  end

  always_comb begin
    tags_match = 1'b1;
    for (int i = 1; i < NUM_INPUTS; i++) begin
      if (out_data[i][PAYLOAD_WIDTH-1 -: TAG_WIDTH] !=
          out_data[0][PAYLOAD_WIDTH-1 -: TAG_WIDTH])
        tags_match = 1'b0;
    end
  end

  // Empty lanes are a wait, never a mismatch.
  assign all_nonempty = &(~lane_empty);
  assign heads_ok     = all_nonempty && tags_match;
  assign mismatch     = all_nonempty && !tags_match;
  assign out_valid    = {NUM_INPUTS{heads_ok && !error_valid}};
  assign fire         = out_valid[0] && (&out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_valid <= 1'b0;
      error_code  <= '0;
    end else if (!error_valid && mismatch) begin
      error_valid <= 1'b1;
      error_code  <= RT_TEMPORAL_ALIGN_TAG_MISMATCH;
    end
  end

endmodule

// File: tb/tb_fabric_temporal_operand_align.sv
// Directed bench for the operand alignment stage (2 lanes, depth 2).
module tb_fabric_temporal_operand_align;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int PW = DW + TW;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N-1:0][PW-1:0] in_data;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [N-1:0][PW-1:0] out_data;
  logic              error_valid;
  logic [15:0]       error_code;

  int checks = 0;
  int errors = 0;

  fabric_temporal_operand_align #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .DEPTH      (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .error_valid (error_valid),
    .error_code  (error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pl(input logic [TW-1:0] tag, input logic [DW-1:0] val);
    return {tag, val};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    in_data = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL reset_out_valid: got %b want 00", out_valid);
    end
    checks++;
    if (in_ready !== 2'b11) begin
      errors++; $display("FAIL reset_in_ready: got %b want 11", in_ready);
    end
    checks++;
    if (error_valid !== 1'b0 || error_code !== 16'd0) begin
      errors++; $display("FAIL reset_error: got %b/%0d want 0/0", error_valid, error_code);
    end
  endtask

  task automatic test_aligned();
    out_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      in_valid = 2'b11;
      in_data[0] = pl(4'd3, 32'(k));
      in_data[1] = pl(4'd3, 32'(k + 100));
      step();
      checks++;
      if (out_valid !== 2'b11 || out_data[0] !== pl(4'd3, 32'(k)) ||
          out_data[1] !== pl(4'd3, 32'(k + 100))) begin
        errors++;
        $display("FAIL aligned_set%0d: got v=%b %h %h want v=11 %h %h", k, out_valid,
                 out_data[0], out_data[1], pl(4'd3, 32'(k)), pl(4'd3, 32'(k + 100)));
      end
      checks++;
      if (in_ready !== 2'b11) begin
        errors++; $display("FAIL aligned_ready%0d: got %b want 11", k, in_ready);
      end
    end
    in_valid = 2'b00;
    step();
    checks++;
    if (out_valid !== 2'b00 || error_valid !== 1'b0) begin
      errors++; $display("FAIL aligned_drain: got v=%b err=%b want 00/0", out_valid, error_valid);
    end
  endtask

  task automatic test_skew();
    out_ready = 2'b11;
    in_valid = 2'b01;
    in_data[0] = pl(4'd5, 32'h11);
    step();
    in_valid = 2'b00;
    for (int t = 1; t <= 4; t++) begin
      checks++;
      if (out_valid !== 2'b00) begin
        errors++; $display("FAIL skew_wait_t%0d: got %b want 00", t, out_valid);
      end
      if (t < 4) step();
    end
    in_valid = 2'b10;
    in_data[1] = pl(4'd5, 32'h22);
    step();
    in_valid = 2'b00;
    checks++;
    if (out_valid !== 2'b11 || out_data[0] !== pl(4'd5, 32'h11) ||
        out_data[1] !== pl(4'd5, 32'h22) || error_valid !== 1'b0) begin
      errors++;
      $display("FAIL skew_t5: got v=%b %h %h err=%b want 11 %h %h 0", out_valid, out_data[0],
               out_data[1], error_valid, pl(4'd5, 32'h11), pl(4'd5, 32'h22));
    end
    step();
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL skew_drain: got %b want 00", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 2'b00;
    in_valid = 2'b01;
    in_data[0] = pl(4'd1, 32'hA0);
    step();
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_ready_after1: got %b want 1", in_ready[0]);
    end
    in_data[0] = pl(4'd1, 32'hA1);
    step();
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL bp_full_after2: got %b want 0", in_ready[0]);
    end
    in_valid = 2'b11;
    in_data[0] = pl(4'd1, 32'hA2);
    in_data[1] = pl(4'd1, 32'hB0);
    step();
    in_data[1] = pl(4'd1, 32'hB1);
    step();
    checks++;
    if (in_ready !== 2'b00 || out_valid !== 2'b11 || out_data[0] !== pl(4'd1, 32'hA0) ||
        out_data[1] !== pl(4'd1, 32'hB0)) begin
      errors++;
      $display("FAIL bp_held: got rdy=%b v=%b %h %h want 00 11 %h %h", in_ready, out_valid,
               out_data[0], out_data[1], pl(4'd1, 32'hA0), pl(4'd1, 32'hB0));
    end
    out_ready = 2'b11;
    in_data[1] = pl(4'd1, 32'hB2);
    step();
    checks++;
    if (out_data[0] !== pl(4'd1, 32'hA1) || out_data[1] !== pl(4'd1, 32'hB1) ||
        in_ready !== 2'b11) begin
      errors++;
      $display("FAIL bp_drain1: got %h %h rdy=%b want %h %h 11", out_data[0], out_data[1],
               in_ready, pl(4'd1, 32'hA1), pl(4'd1, 32'hB1));
    end
    step();
    in_valid = 2'b00;
    checks++;
    if (out_valid !== 2'b11 || out_data[0] !== pl(4'd1, 32'hA2) ||
        out_data[1] !== pl(4'd1, 32'hB2)) begin
      errors++;
      $display("FAIL bp_drain2: got v=%b %h %h want 11 %h %h", out_valid, out_data[0],
               out_data[1], pl(4'd1, 32'hA2), pl(4'd1, 32'hB2));
    end
    step();
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL bp_empty: got %b want 00", out_valid);
    end
  endtask

  task automatic test_partial_ready();
    out_ready = 2'b00;
    in_valid = 2'b11;
    in_data[0] = pl(4'd6, 32'h61);
    in_data[1] = pl(4'd6, 32'h62);
    step();
    in_valid = 2'b00;
    out_ready = 2'b01;
    step();
    out_ready = 2'b10;
    step();
    checks++;
    if (out_valid !== 2'b11 || out_data[0] !== pl(4'd6, 32'h61) ||
        out_data[1] !== pl(4'd6, 32'h62) || in_ready !== 2'b11) begin
      errors++;
      $display("FAIL partial_hold: got v=%b %h %h rdy=%b want 11 %h %h 11", out_valid,
               out_data[0], out_data[1], in_ready, pl(4'd6, 32'h61), pl(4'd6, 32'h62));
    end
    out_ready = 2'b11;
    step();
    checks++;
    if (out_valid !== 2'b00) begin
      errors++; $display("FAIL partial_single_pop: got %b want 00", out_valid);
    end
  endtask

  task automatic test_mismatch();
    out_ready = 2'b11;
    in_valid = 2'b11;
    in_data[0] = pl(4'd2, 32'h20);
    in_data[1] = pl(4'd7, 32'h70);
    step();
    in_valid = 2'b00;
    checks++;
    if (out_valid !== 2'b00 || error_valid !== 1'b0) begin
      errors++; $display("FAIL mm_detect_cycle: got v=%b err=%b want 00/0", out_valid, error_valid);
    end
    step();
    checks++;
    if (error_valid !== 1'b1 || error_code !== 16'd262 || out_valid !== 2'b00 ||
        in_ready !== 2'b00) begin
      errors++;
      $display("FAIL mm_latched: got err=%b code=%0d v=%b rdy=%b want 1 262 00 00",
               error_valid, error_code, out_valid, in_ready);
    end
    in_valid = 2'b11;
    in_data[0] = pl(4'd9, 32'h90);
    in_data[1] = pl(4'd9, 32'h91);
    step();
    step();
    in_valid = 2'b00;
    checks++;
    if (error_valid !== 1'b1 || error_code !== 16'd262 || out_valid !== 2'b00 ||
        out_data[0] !== pl(4'd2, 32'h20) || out_data[1] !== pl(4'd7, 32'h70)) begin
      errors++;
      $display("FAIL mm_frozen: got err=%b code=%0d v=%b %h %h want 1 262 00 %h %h",
               error_valid, error_code, out_valid, out_data[0], out_data[1],
               pl(4'd2, 32'h20), pl(4'd7, 32'h70));
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 2'b00;
    in_valid = 2'b11;
    in_data[0] = pl(4'd9, 32'hC0);
    in_data[1] = pl(4'd9, 32'hD0);
    step();
    in_data[0] = pl(4'd9, 32'hC1);
    in_data[1] = pl(4'd9, 32'hD1);
    step();
    in_valid = 2'b00;
    checks++;
    if (out_valid !== 2'b11 || in_ready !== 2'b00) begin
      errors++; $display("FAIL rst_prefill: got v=%b rdy=%b want 11 00", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 2'b00 || in_ready !== 2'b11) begin
      errors++; $display("FAIL rst_async: got v=%b rdy=%b want 00 11", out_valid, in_ready);
    end
    step();
    #3;
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 2'b00 || in_ready !== 2'b11 || error_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: got v=%b rdy=%b err=%b want 00 11 0", out_valid, in_ready,
               error_valid);
    end
    out_ready = 2'b11;
    in_valid = 2'b11;
    in_data[0] = pl(4'd4, 32'hE0);
    in_data[1] = pl(4'd4, 32'hE1);
    step();
    in_valid = 2'b00;
    checks++;
    if (out_valid !== 2'b11 || out_data[0] !== pl(4'd4, 32'hE0) ||
        out_data[1] !== pl(4'd4, 32'hE1)) begin
      errors++;
      $display("FAIL rst_fresh_set: got v=%b %h %h want 11 %h %h", out_valid, out_data[0],
               out_data[1], pl(4'd4, 32'hE0), pl(4'd4, 32'hE1));
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    in_data = '0;
    test_reset();
    test_aligned();
    test_skew();
    test_backpressure();
    test_partial_ready();
    test_mismatch();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
